// File: rtl/alu_mul_seq.sv
// alu_mul_seq: sequential unsigned multiplier front-end for a combinational ALU.
// Computes result = a_in * b_in by repeated addition. The latched multiplicand and
// the accumulator are driven to the ALU each cycle; the ALU sum and its overflow
// flag are captured back on the next clock edge.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start             request, sampled only while idle
//   a_in, b_in        multiplicand / multiplier (iteration count), latched on accept
//   busy, done        busy in LOAD/ITER/DONE; done is a one-cycle pulse in DONE
//   result, overflow  registered product and sticky overflow for the operation
//   alu_a, alu_b      ALU operands (multiplicand, accumulator), register-driven
//   alu_op            constant addition opcode
//   alu_o, alu_of     ALU sum and overflow flag
//
// Build option: define MUL_SEQ_SWAP_EN to iterate over min(a,b) instead of b.
module alu_mul_seq #(
    parameter int unsigned WIDTH  = 8,
    parameter logic [3:0]  OP_ADD = 4'd0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] alu_o,
    input  logic             alu_of
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ITER,
        DONE
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] cnt;
    logic             zero_op;

    assign zero_op = (a_reg == '0) || (b_reg == '0);
    assign alu_a   = a_reg;
    assign alu_b   = acc;
    assign alu_op  = OP_ADD;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b1;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                state_next = zero_op ? DONE : ITER;
            end
            ITER: begin
                // Abort on overflow, otherwise finish after the add with cnt==1.
                if (alu_of || (cnt == WIDTH'(1))) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg    <= '0;
            b_reg    <= '0;
            acc      <= '0;
            cnt      <= '0;
            result   <= '0;
            overflow <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_reg    <= a_in;
                        b_reg    <= b_in;
                        overflow <= 1'b0;
                    end
                end
                LOAD: begin
                    acc <= '0;
`ifdef MUL_SEQ_SWAP_EN
                    // Iterate over the smaller operand; the product is unchanged.
                    if (a_reg >= b_reg) begin
                        cnt <= b_reg;
                    end else begin
                        a_reg <= b_reg;
                        cnt   <= a_reg;
                    end
`else
                    cnt <= b_reg;
`endif
                    if (zero_op) begin
                        result <= '0;
                    end
                end
                ITER: begin
                    if (alu_of) begin
                        // Keep the last partial sum that still fit in WIDTH bits.
                        overflow <= 1'b1;
                        result   <= acc;
                    end else begin
                        acc <= alu_o;
                        cnt <= cnt - WIDTH'(1);
                        if (cnt == WIDTH'(1)) begin
                            result <= alu_o;
                        end
                    end
                end
                DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

endmodule
